// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the hazard scoreboard: forward-mux selects,
// T_use/T_new limits and stage indices.
package hazard_scoreboard_pkg;

  // Forward-mux select encodings (D stage uses all four; E/M use a subset)
  localparam logic [1:0] FWD_GRF = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;
  localparam logic [1:0] FWD_E   = 2'b11;

  // T_use value meaning "operand not read"; largest T_new a producer can carry
  localparam int unsigned TUSE_NONE = 3;
  localparam int unsigned TNEW_MAX  = 2;

  // Tracked stages, nearest (youngest) first
  typedef enum logic [1:0] {
    STG_E = 2'd0,
    STG_M = 2'd1,
    STG_W = 2'd2
  } stage_e;

  localparam int NSTG = 3;

  // Map the stage holding the nearest ready producer to its forward select
  function automatic logic [1:0] stage_fwd(input logic [1:0] idx);
    logic [1:0] sel;
    case (stage_e'(idx))
      STG_E:   sel = FWD_E;
      STG_M:   sel = FWD_M;
      STG_W:   sel = FWD_W;
      default: sel = FWD_GRF;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_stage_reg.sv
// One scoreboard entry {dst, tnew, rs, rt}. A bubble clears the entry;
// when DEC is set the captured tnew is one less than the incoming value,
// saturating at zero, so it tracks the producer moving one stage on.
module hz_stage_reg
  import hazard_scoreboard_pkg::*;
#(
  parameter int RA_W = 5,
  parameter int TN_W = 2,
  parameter bit DEC  = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            bubble_i,
  input  logic [RA_W-1:0] dst_i,
  input  logic [TN_W-1:0] tnew_i,
  input  logic [RA_W-1:0] rs_i,
  input  logic [RA_W-1:0] rt_i,
  output logic [RA_W-1:0] dst_o,
  output logic [TN_W-1:0] tnew_o,
  output logic [RA_W-1:0] rs_o,
  output logic [RA_W-1:0] rt_o
);

  logic [RA_W-1:0] dst_q, rs_q, rt_q;
  logic [TN_W-1:0] tnew_q, tnew_d;

  // Saturating countdown of cycles until the producer's result exists
  always_comb begin
    tnew_d = tnew_i;
    if (DEC && tnew_i != '0) tnew_d = tnew_i - TN_W'(1);
  end

  // Entry register; reset and bubbles both leave an inert entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dst_q  <= '0;
      tnew_q <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
    end else if (bubble_i) begin
      dst_q  <= '0;
      tnew_q <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
    end else begin
      dst_q  <= dst_i;
      tnew_q <= tnew_d;
      rs_q   <= rs_i;
      rt_q   <= rt_i;
    end
  end

  assign dst_o  = dst_q;
  assign tnew_o = tnew_q;
  assign rs_o   = rs_q;
  assign rt_o   = rt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight GPR writes in E/M/W and derives the
// D-stage stall plus D/E/M forward-mux selects. Nearest producer always
// wins; a select is only raised when that nearest producer is ready.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int RA_W = 5,
  parameter int TN_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] rs_d,
  input  logic [RA_W-1:0] rt_d,
  input  logic [TN_W-1:0] tuse_rs_d,
  input  logic [TN_W-1:0] tuse_rt_d,
  input  logic            we_d,
  input  logic [RA_W-1:0] dst_d,
  input  logic [TN_W-1:0] tnew_d,
  output logic            stall,
  output logic [1:0]      fwd_rs_d,
  output logic [1:0]      fwd_rt_d,
  output logic [1:0]      fwd_rs_e,
  output logic [1:0]      fwd_rt_e,
  output logic [1:0]      fwd_rt_m
);

  // Index 0 = E, 1 = M, 2 = W
  logic [NSTG-1:0][RA_W-1:0] dst_in, rs_in, rt_in;
  logic [NSTG-1:0][TN_W-1:0] tnew_in;
  logic [NSTG-1:0]           bub;
  logic [NSTG-1:0][RA_W-1:0] dst_q, rs_q, rt_q;
  logic [NSTG-1:0][TN_W-1:0] tnew_q;

  for (genvar g = 0; g < NSTG; g++) begin : g_stg
    if (g == 0) begin : g_head
      // E captures the D instruction, or a bubble while D is held
      assign dst_in[g]  = we_d ? dst_d : '0;
      assign tnew_in[g] = tnew_d;
      assign rs_in[g]   = rs_d;
      assign rt_in[g]   = rt_d;
      assign bub[g]     = stall;
    end else begin : g_tail
      // M and W advance unconditionally
      assign dst_in[g]  = dst_q[g-1];
      assign tnew_in[g] = tnew_q[g-1];
      assign rs_in[g]   = rs_q[g-1];
      assign rt_in[g]   = rt_q[g-1];
      assign bub[g]     = 1'b0;
    end

    hz_stage_reg #(
      .RA_W (RA_W),
      .TN_W (TN_W),
      .DEC  (g != 0)
    ) u_stg (
      .clk      (clk),
      .reset    (reset),
      .bubble_i (bub[g]),
      .dst_i    (dst_in[g]),
      .tnew_i   (tnew_in[g]),
      .rs_i     (rs_in[g]),
      .rt_i     (rt_in[g]),
      .dst_o    (dst_q[g]),
      .tnew_o   (tnew_q[g]),
      .rs_o     (rs_q[g]),
      .rt_o     (rt_q[g])
    );
  end

  // {hit, stage} of the nearest stage at or beyond lo writing r; $0 never hits
  function automatic logic [2:0] nearest(input logic [RA_W-1:0]           r,
                                         input logic [NSTG-1:0][RA_W-1:0] dst,
                                         input int                        lo);
    logic [2:0] res;
    res = '0;
    // Walk oldest to youngest so the youngest match overwrites older ones
    for (int s = NSTG - 1; s >= 0; s--) begin
      if (s >= lo && r != '0 && dst[s] == r) res = {1'b1, 2'(s)};
    end
    return res;
  endfunction

  // Select only when the nearest producer has its result in hand
  function automatic logic [1:0] fwd_sel(input logic [2:0]                hit,
                                         input logic [NSTG-1:0][TN_W-1:0] tn);
    logic [1:0] sel;
    sel = FWD_GRF;
    if (hit[2] && tn[hit[1:0]] == '0) sel = stage_fwd(hit[1:0]);
    return sel;
  endfunction

  logic [2:0] h_rs_d, h_rt_d, h_rs_e, h_rt_e, h_rt_m;
  logic       stall_rs, stall_rt;

  // Match, stall and forward decode, purely from state and D inputs
  always_comb begin
    h_rs_d   = nearest(rs_d,     dst_q, 0);
    h_rt_d   = nearest(rt_d,     dst_q, 0);
    h_rs_e   = nearest(rs_q[0],  dst_q, 1);
    h_rt_e   = nearest(rt_q[0],  dst_q, 1);
    h_rt_m   = nearest(rt_q[1],  dst_q, 2);
    stall_rs = h_rs_d[2] && (tnew_q[h_rs_d[1:0]] > tuse_rs_d);
    stall_rt = h_rt_d[2] && (tnew_q[h_rt_d[1:0]] > tuse_rt_d);
    stall    = stall_rs || stall_rt;
    fwd_rs_d = fwd_sel(h_rs_d, tnew_q);
    fwd_rt_d = fwd_sel(h_rt_d, tnew_q);
    fwd_rs_e = fwd_sel(h_rs_e, tnew_q);
    fwd_rt_e = fwd_sel(h_rt_e, tnew_q);
    fwd_rt_m = fwd_sel(h_rt_m, tnew_q);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed table, two multi-cycle sequences,
// then random traffic against a ready-time based pipeline model.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] rs_d = '0, rt_d = '0, dst_d = '0;
  logic [1:0] tuse_rs_d = 2'd3, tuse_rt_d = 2'd3, tnew_d = '0;
  logic       we_d = 1'b0;
  logic       stall;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.RA_W(5), .TN_W(2)) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
    .we_d(we_d), .dst_d(dst_d), .tnew_d(tnew_d),
    .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m)
  );

  // Expected output word {stall, rs_d, rt_d, rs_e, rt_e, rt_m}
  function automatic logic [10:0] ex(int st, int a, int b, int c, int d, int e);
    return {1'(st), 2'(a), 2'(b), 2'(c), 2'(d), 2'(e)};
  endfunction

  task automatic chk(input string nm, input logic [10:0] exp);
    logic [10:0] act;
    act = {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m};
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic drv(input int rs, input int rt, input int trs, input int trt,
                     input int we, input int dst, input int tn);
    rs_d = 5'(rs); rt_d = 5'(rt); tuse_rs_d = 2'(trs); tuse_rt_d = 2'(trt);
    we_d = 1'(we); dst_d = 5'(dst); tnew_d = 2'(tn);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drv(0, 0, 3, 3, 0, 0, 0);
    next_cyc();
    reset = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          rst;
    int          rs, rt, trs, trt, we, dst, tn;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input bit rst, input int rs, input int rt, input int trs,
                     input int trt, input int we, input int dst, input int tn,
                     input logic [10:0] exp);
    vec_t v;
    v.rst = rst; v.rs = rs; v.rt = rt; v.trs = trs; v.trt = trt;
    v.we = we; v.dst = dst; v.tn = tn; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic nop(input logic [10:0] exp);
    row(0, 0, 0, 3, 3, 0, 0, 0, exp);
  endtask

  task automatic rst_row();
    row(1, 0, 0, 3, 3, 0, 0, 0, ex(0,0,0,0,0,0));
  endtask

  // ---------------- reference model ----------------
  // Each entry remembers the absolute cycle its result becomes available.
  typedef struct { int dst; int rdy; int rs; int rt; } ent_t;
  ent_t pipe[3];
  int   cyc = 0;

  function automatic int tn_of(int s);
    return (pipe[s].rdy > cyc) ? pipe[s].rdy - cyc : 0;
  endfunction

  function automatic int near(int r, int lo);
    for (int s = lo; s < 3; s++)
      if (r != 0 && pipe[s].dst == r) return s;
    return -1;
  endfunction

  function automatic int sel_of(int s);
    if (s < 0) return 0;
    if (tn_of(s) != 0) return 0;
    return 3 - s;
  endfunction

  function automatic logic [10:0] model_exp(int rs, int rt, int trs, int trt);
    int hs, ht;
    bit st;
    hs = near(rs, 0);
    ht = near(rt, 0);
    st = (hs >= 0 && tn_of(hs) > trs) || (ht >= 0 && tn_of(ht) > trt);
    return ex(int'(st), sel_of(hs), sel_of(ht),
              sel_of(near(pipe[0].rs, 1)), sel_of(near(pipe[0].rt, 1)),
              sel_of(near(pipe[1].rt, 2)));
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 3; s++) pipe[s] = '{0, 0, 0, 0};
  endtask

  task automatic model_clock(input bit st, input int rs, input int rt,
                             input int we, input int dst, input int tn);
    cyc++;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    if (st) pipe[0] = '{0, 0, 0, 0};
    else    pipe[0] = '{(we != 0) ? dst : 0, cyc + tn, rs, rt};
  endtask

  initial begin
    // lw $8 ; add $9,$8,$8 : one-cycle stall, then E forwards from W
    rst_row();
    row(0, 0, 0, 1, 3, 1, 8, 2, ex(0,0,0,0,0,0));
    row(0, 8, 8, 1, 1, 1, 9, 1, ex(1,0,0,0,0,0));
    row(0, 8, 8, 1, 1, 1, 9, 1, ex(0,0,0,0,0,0));
    nop(ex(0,0,0,1,1,0));
    nop(ex(0,0,0,0,0,0));
    // ori $5 ; sw $5 : no stall, store data forwarded in E then in M
    rst_row();
    row(0, 0, 0, 1, 3, 1, 5, 1, ex(0,0,0,0,0,0));
    row(0, 0, 5, 1, 2, 0, 0, 0, ex(0,0,0,0,0,0));
    nop(ex(0,0,0,0,2,0));
    nop(ex(0,0,0,0,0,1));
    // jal ; jr $31 : forwarded from E in D, then from M in E
    rst_row();
    row(0, 0, 0, 3, 3, 1, 31, 0, ex(0,0,0,0,0,0));
    row(0, 31, 0, 0, 3, 0, 0, 0, ex(0,3,0,0,0,0));
    nop(ex(0,0,0,2,0,0));
    // writes to $0 are inert
    rst_row();
    row(0, 0, 0, 1, 3, 1, 0, 1, ex(0,0,0,0,0,0));
    row(0, 0, 0, 1, 1, 1, 2, 1, ex(0,0,0,0,0,0));
    nop(ex(0,0,0,0,0,0));
    // ori $3 ; lw $3 ; add $3,$3 : the pending lw shadows the ready ori
    rst_row();
    row(0, 0, 0, 1, 3, 1, 3, 1, ex(0,0,0,0,0,0));
    row(0, 0, 0, 1, 3, 1, 3, 2, ex(0,0,0,0,0,0));
    row(0, 3, 3, 1, 1, 1, 4, 1, ex(1,0,0,0,0,0));
    row(0, 3, 3, 1, 1, 1, 4, 1, ex(0,0,0,0,0,0));

    next_cyc();
    next_cyc();
    reset = 1'b0;

    // reset state
    @(negedge clk);
    chk("reset_state", ex(0,0,0,0,0,0));
    next_cyc();

    foreach (tbl[i]) begin
      reset = tbl[i].rst;
      drv(tbl[i].rs, tbl[i].rt, tbl[i].trs, tbl[i].trt, tbl[i].we, tbl[i].dst, tbl[i].tn);
      @(negedge clk);
      chk($sformatf("tbl%0d", i), tbl[i].exp);
      next_cyc();
    end
    reset = 1'b0;

    // reset asserted while a load-use stall is active
    do_reset();
    drv(0, 0, 1, 3, 1, 8, 2);
    next_cyc();
    drv(8, 8, 1, 1, 1, 9, 1);
    @(negedge clk);
    chk("t1_stall", ex(1,0,0,0,0,0));
    reset = 1'b1;
    #1;
    chk("t1_async_rst", ex(0,0,0,0,0,0));
    next_cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("t1_after_rel", ex(0,0,0,0,0,0));
    next_cyc();

    // lw $8 ; beq $8,$0 : two stall cycles, then forward from W
    do_reset();
    drv(0, 0, 1, 3, 1, 8, 2);
    @(negedge clk);
    chk("t3_lw", ex(0,0,0,0,0,0));
    next_cyc();
    drv(8, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t3_stall1", ex(1,0,0,0,0,0));
    next_cyc();
    @(negedge clk);
    chk("t3_stall2", ex(1,0,0,0,0,0));
    next_cyc();
    @(negedge clk);
    chk("t3_fwd_w", ex(0,1,0,0,0,0));
    next_cyc();

    // random traffic against the model
    do_reset();
    model_clear();
    for (int n = 0; n < 400; n++) begin
      int rs, rt, trs, trt, we, dst, tn;
      bit r;
      logic [10:0] e;
      rs  = $urandom_range(0, 4);
      rt  = $urandom_range(0, 4);
      trs = $urandom_range(0, 3);
      trt = $urandom_range(0, 3);
      we  = $urandom_range(0, 1);
      dst = $urandom_range(0, 4);
      tn  = $urandom_range(0, 2);
      r   = ($urandom_range(0, 39) == 0);
      reset = r;
      if (r) model_clear();
      drv(rs, rt, trs, trt, we, dst, tn);
      @(negedge clk);
      e = model_exp(rs, rt, trs, trt);
      chk($sformatf("rnd%0d", n), e);
      @(posedge clk);
      if (r) model_clear();
      else   model_clock(e[10], rs, rt, we, dst, tn);
      #1;
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
